// File: rtl/lpm_router_searcher.sv
`default_nettype none
// lpm_router_searcher: longest-prefix-match route table with runtime updates, a 3-stage
// backpressured lookup pipeline and saturating hit/miss counters.
module lpm_router_searcher #(
  parameter int MAX_ENTRIES = 64,
  parameter int IDX_W       = $clog2(MAX_ENTRIES),
  parameter int ENTRY_WIDTH = 256,
  parameter int IP_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [IDX_W-1:0]       upd_addr,
  input  logic [ENTRY_WIDTH-1:0] upd_data,
  input  logic                   clear_all,
  input  logic                   lookup_valid,
  output logic                   lookup_ready,
  input  logic [IP_WIDTH-1:0]    lookup_dst_ip,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_found,
  output logic                   resp_is_default_route,
  output logic                   resp_is_direct_host,
  output logic                   resp_is_broadcast,
  output logic [5:0]             resp_prefix_len,
  output logic [IDX_W-1:0]       resp_idx,
  output logic [15:0]            resp_out_port,
  output logic [15:0]            resp_out_qp,
  output logic [15:0]            resp_next_hop_port,
  output logic [15:0]            resp_next_hop_qp,
  output logic [31:0]            resp_next_hop_ip,
  output logic [47:0]            resp_next_hop_mac,
  output logic [31:0]            stat_hits,
  output logic [31:0]            stat_misses
);

  localparam logic [5:0] MAX_LEN = 6'd32;
  localparam int         PAY_W   = 144;

  logic [IP_WIDTH-1:0]    tbl_ip  [MAX_ENTRIES];
  logic [5:0]             tbl_len [MAX_ENTRIES];
  logic [PAY_W-1:0]       tbl_pay [MAX_ENTRIES];
  logic [MAX_ENTRIES-1:0] tbl_valid;
  logic [MAX_ENTRIES-1:0] tbl_direct;
  logic [MAX_ENTRIES-1:0] tbl_bcast;

  logic                advance, lookup_fire, tbl_write, tbl_clear;
  logic [5:0]          wr_len;
  logic                unused_bits;
  logic                best_found;
  logic [5:0]          best_len;
  logic [IDX_W-1:0]    best_idx;

  logic                s1_valid;
  logic [IP_WIDTH-1:0] s1_ip;
  logic                s2_valid, s2_found;
  logic [5:0]          s2_len;
  logic [IDX_W-1:0]    s2_idx;
  logic                s3_valid, s3_found, s3_direct, s3_bcast;
  logic [5:0]          s3_len;
  logic [IDX_W-1:0]    s3_idx;
  logic [PAY_W-1:0]    s3_pay;

  function automatic logic [IP_WIDTH-1:0] prefix_mask(input logic [5:0] len);
    return (len == 6'd0) ? '0 : ({IP_WIDTH{1'b1}} << (MAX_LEN - len));
  endfunction

  assign advance      = !resp_valid || resp_ready;
  assign lookup_ready = advance && !upd_valid && !clear_all;
  assign lookup_fire  = lookup_valid && lookup_ready;
  assign upd_ready    = !s1_valid && !s2_valid && !s3_valid && !resp_valid;
  assign tbl_clear    = clear_all && upd_ready;
  assign tbl_write    = upd_valid && upd_ready && !clear_all;
  assign wr_len       = (upd_data[61:56] > MAX_LEN) ? MAX_LEN : upd_data[61:56];
  assign unused_bits  = ^upd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
    end else if (tbl_clear) begin
      tbl_valid <= '0;
    end else if (tbl_write) begin
      tbl_valid[upd_addr] <= upd_data[32];
    end
  end

  // Entry payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (tbl_write) begin
      tbl_ip[upd_addr]     <= upd_data[IP_WIDTH-1:0];
      tbl_len[upd_addr]    <= wr_len;
      tbl_direct[upd_addr] <= upd_data[40];
      tbl_bcast[upd_addr]  <= upd_data[48];
      tbl_pay[upd_addr]    <= upd_data[207:64];
    end
  end

  // Strictly-greater compare keeps the lowest index on equal prefix lengths.
  always_comb begin
    best_found = 1'b0;
    best_len   = '0;
    best_idx   = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (tbl_valid[i] && (((tbl_ip[i] ^ s1_ip) & prefix_mask(tbl_len[i])) == '0) &&
          (!best_found || (tbl_len[i] > best_len))) begin
        best_found = 1'b1;
        best_len   = tbl_len[i];
        best_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_ip <= '0;
      s2_valid <= 1'b0; s2_found <= 1'b0; s2_len <= '0; s2_idx <= '0;
      s3_valid <= 1'b0; s3_found <= 1'b0; s3_direct <= 1'b0; s3_bcast <= 1'b0;
      s3_len <= '0; s3_idx <= '0; s3_pay <= '0;
      resp_valid <= 1'b0; resp_found <= 1'b0; resp_is_default_route <= 1'b0;
      resp_is_direct_host <= 1'b0; resp_is_broadcast <= 1'b0;
      resp_prefix_len <= '0; resp_idx <= '0;
      resp_out_port <= '0; resp_out_qp <= '0; resp_next_hop_ip <= '0;
      resp_next_hop_port <= '0; resp_next_hop_qp <= '0; resp_next_hop_mac <= '0;
    end else if (advance) begin
      s1_valid <= lookup_fire;
      s1_ip    <= lookup_dst_ip;
      s2_valid <= s1_valid;
      s2_found <= s1_valid && best_found;
      s2_len   <= best_len;
      s2_idx   <= best_idx;
      s3_valid  <= s2_valid;
      s3_found  <= s2_found;
      s3_len    <= s2_len;
      s3_idx    <= s2_idx;
      s3_direct <= tbl_direct[s2_idx];
      s3_bcast  <= tbl_bcast[s2_idx];
      s3_pay    <= tbl_pay[s2_idx];
      // A miss or bubble drives every data field to zero.
      resp_valid            <= s3_valid;
      resp_found            <= s3_found;
      resp_is_default_route <= s3_found && (s3_len == 6'd0);
      resp_is_direct_host   <= s3_found && s3_direct;
      resp_is_broadcast     <= s3_found && s3_bcast;
      resp_prefix_len       <= s3_found ? s3_len : '0;
      resp_idx              <= s3_found ? s3_idx : '0;
      resp_out_port         <= s3_found ? s3_pay[15:0]   : '0;
      resp_out_qp           <= s3_found ? s3_pay[31:16]  : '0;
      resp_next_hop_ip      <= s3_found ? s3_pay[63:32]  : '0;
      resp_next_hop_port    <= s3_found ? s3_pay[79:64]  : '0;
      resp_next_hop_qp      <= s3_found ? s3_pay[95:80]  : '0;
      resp_next_hop_mac     <= s3_found ? s3_pay[143:96] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (resp_valid && resp_ready) begin
      if (resp_found) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else if (stat_misses != '1) begin
        stat_misses <= stat_misses + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lpm_router_searcher.sv
`default_nettype none
// Bench for lpm_router_searcher: directed vector table, stall/drain/saturation/reset
// sequences, and randomized traffic scored against a behavioural longest-prefix model.
module tb_lpm_router_searcher;
  localparam int N  = 64;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic upd_valid = 1'b0, clear_all = 1'b0, upd_ready;
  logic [IW-1:0] upd_addr = '0;
  logic [255:0] upd_data = '0;
  logic lookup_valid = 1'b0, lookup_ready;
  logic [31:0] lookup_dst_ip = '0;
  logic resp_valid, resp_ready = 1'b1;
  logic resp_found, resp_is_default_route, resp_is_direct_host, resp_is_broadcast;
  logic [5:0] resp_prefix_len;
  logic [IW-1:0] resp_idx;
  logic [15:0] resp_out_port, resp_out_qp, resp_next_hop_port, resp_next_hop_qp;
  logic [31:0] resp_next_hop_ip, stat_hits, stat_misses;
  logic [47:0] resp_next_hop_mac;

  lpm_router_searcher dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_data(upd_data),
    .clear_all(clear_all),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_dst_ip(lookup_dst_ip),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_found(resp_found),
    .resp_is_default_route(resp_is_default_route), .resp_is_direct_host(resp_is_direct_host),
    .resp_is_broadcast(resp_is_broadcast), .resp_prefix_len(resp_prefix_len), .resp_idx(resp_idx),
    .resp_out_port(resp_out_port), .resp_out_qp(resp_out_qp),
    .resp_next_hop_port(resp_next_hop_port), .resp_next_hop_qp(resp_next_hop_qp),
    .resp_next_hop_ip(resp_next_hop_ip), .resp_next_hop_mac(resp_next_hop_mac),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic found, dflt, direct, bcast;
    logic [5:0] len;
    logic [5:0] idx;
    logic [15:0] port, qp, nh_port, nh_qp;
    logic [31:0] nh_ip;
    logic [47:0] nh_mac;
  } resp_t;

  typedef struct {
    logic [31:0] q;
    logic        found;
    logic [5:0]  idx;
    logic [5:0]  len;
    logic [15:0] port;
    logic        dflt;
  } vec_t;

  vec_t vecs [9];
  logic m_valid [N];
  logic [255:0] m_data [N];
  resp_t exp_q [$];
  resp_t mon_exp, snap;
  logic [31:0] m_hits, m_misses, h0, m0;
  int checks = 0, failures = 0, consumed = 0;
  int lat, t, c0, r;
  logic acc_l, acc_u;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic resp_t dut_resp();
    resp_t x;
    x.found = resp_found; x.dflt = resp_is_default_route;
    x.direct = resp_is_direct_host; x.bcast = resp_is_broadcast;
    x.len = resp_prefix_len; x.idx = resp_idx;
    x.port = resp_out_port; x.qp = resp_out_qp;
    x.nh_port = resp_next_hop_port; x.nh_qp = resp_next_hop_qp;
    x.nh_ip = resp_next_hop_ip; x.nh_mac = resp_next_hop_mac;
    return x;
  endfunction

  // Reference: compare the top len bits of each valid entry, keep the longest, first wins ties.
  function automatic resp_t model_lookup(input logic [31:0] q);
    resp_t x;
    int best, blen;
    x = '0; best = -1; blen = -1;
    for (int i = 0; i < N; i++) begin
      int l;
      if (m_valid[i] !== 1'b1) continue;
      l = int'(m_data[i][61:56]);
      if (l > 32) l = 32;
      if ((l == 0 || (m_data[i][31:0] >> (32 - l)) == (q >> (32 - l))) && l > blen) begin
        best = i; blen = l;
      end
    end
    if (best >= 0) begin
      x.found = 1'b1; x.dflt = (blen == 0);
      x.direct = m_data[best][40]; x.bcast = m_data[best][48];
      x.len = 6'(blen); x.idx = 6'(best);
      x.port = m_data[best][79:64]; x.qp = m_data[best][95:80];
      x.nh_ip = m_data[best][127:96]; x.nh_port = m_data[best][143:128];
      x.nh_qp = m_data[best][159:144]; x.nh_mac = m_data[best][207:160];
    end
    return x;
  endfunction

  function automatic logic [255:0] make_entry(input logic [31:0] ip, input int len, input logic [15:0] port);
    logic [255:0] d;
    d = '0;
    d[31:0] = ip; d[32] = 1'b1; d[40] = (len >= 32); d[48] = port[0];
    d[61:56] = 6'(len);
    d[79:64] = port; d[95:80] = port + 16'd100; d[127:96] = ~ip;
    d[143:128] = port + 16'd200; d[159:144] = port + 16'd300;
    d[207:160] = {32'hA0B0C0D0, port};
    d[255:208] = 48'hDEAD_BEEF_5A5A;
    return d;
  endfunction

  function automatic logic [255:0] rand_entry();
    logic [255:0] d;
    int len;
    len = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 40));
    d = make_entry({8'd10 + 8'($urandom_range(0, 3)), 24'($urandom)}, len, 16'($urandom));
    d[32] = ($urandom_range(0, 7) != 0);
    return d;
  endfunction

  function automatic logic [31:0] rand_query();
    int j;
    j = int'($urandom_range(0, N - 1));
    if ($urandom_range(0, 1) == 1 && m_valid[j] === 1'b1)
      return m_data[j][31:0] ^ (32'($urandom) >> $urandom_range(4, 31));
    return {8'd10 + 8'($urandom_range(0, 4)), 24'($urandom)};
  endfunction

  // Scoreboard: stats first (they reflect earlier edges), then this cycle's handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_hits = '0; m_misses = '0;
    end else begin
      check("stat_hits", stat_hits, m_hits);
      check("stat_misses", stat_misses, m_misses);
      if (resp_valid && resp_ready) begin
        consumed++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp: got response %0h with no lookup outstanding", dut_resp());
        end else begin
          mon_exp = exp_q.pop_front();
          check("resp", dut_resp(), mon_exp);
          if (mon_exp.found) m_hits = (m_hits == 32'hFFFFFFFF) ? m_hits : m_hits + 32'd1;
          else m_misses = (m_misses == 32'hFFFFFFFF) ? m_misses : m_misses + 32'd1;
        end
      end
      if (clear_all && upd_ready) begin
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      end else if (upd_valid && upd_ready) begin
        m_valid[upd_addr] = upd_data[32];
        m_data[upd_addr] = upd_data;
      end
      if (lookup_valid && lookup_ready) exp_q.push_back(model_lookup(lookup_dst_ip));
    end
  end

  task automatic do_write(input int idx, input logic [255:0] d);
    int k;
    @(posedge clk); #1;
    upd_addr = 6'(idx); upd_data = d; upd_valid = 1'b1;
    k = 0;
    while (!upd_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (k >= 200) begin checks++; failures++; $display("FAIL upd_timeout: upd_ready=0 required 1"); end
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic send_lookup(input logic [31:0] q);
    int k;
    lookup_dst_ip = q; lookup_valid = 1'b1;
    k = 0;
    while (!lookup_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (k >= 200) begin checks++; failures++; $display("FAIL lookup_timeout: lookup_ready=0 required 1"); end
    @(posedge clk); #1;
    lookup_valid = 1'b0;
  endtask

  // Called just after a clock edge with an idle pipeline; returns edges until resp_valid.
  task automatic do_lookup(input logic [31:0] q, output int l);
    lookup_dst_ip = q; lookup_valid = 1'b1;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    l = 0;
    while (l < 20) begin
      @(posedge clk); #1; l++;
      if (resp_valid) break;
    end
    if (!resp_valid) begin checks++; failures++; $display("FAIL resp_timeout: resp_valid=0 required 1"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0A010203, 1'b1, 6'd1, 6'd16, 16'd2,  1'b0};
    vecs[1] = '{32'h0A020001, 1'b1, 6'd0, 6'd8,  16'd1,  1'b0};
    vecs[2] = '{32'hC0A80001, 1'b0, 6'd0, 6'd0,  16'd0,  1'b0};
    vecs[3] = '{32'hAC10054D, 1'b1, 6'd3, 6'd24, 16'd3,  1'b0};
    vecs[4] = '{32'h08080808, 1'b1, 6'd9, 6'd32, 16'd11, 1'b0};
    vecs[5] = '{32'h08080809, 1'b0, 6'd0, 6'd0,  16'd0,  1'b0};
    vecs[6] = '{32'hC0A80001, 1'b1, 6'd5, 6'd0,  16'd9,  1'b1};
    vecs[7] = '{32'h08080809, 1'b1, 6'd5, 6'd0,  16'd9,  1'b1};
    vecs[8] = '{32'h0A010203, 1'b1, 6'd1, 6'd16, 16'd2,  1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_resp", dut_resp(), '0);
    check("reset_stats", {stat_hits, stat_misses}, '0);
    check("reset_ready", {resp_valid, lookup_ready, upd_ready}, 3'b011);
    rst_n = 1'b1;

    do_write(0, make_entry(32'h0A000000, 8, 16'd1));
    do_write(1, make_entry(32'h0A010000, 16, 16'd2));
    do_write(3, make_entry(32'hAC100500, 24, 16'd3));
    do_write(7, make_entry(32'hAC100500, 24, 16'd7));
    do_write(9, make_entry(32'h08080808, 40, 16'd11));

    for (int i = 0; i < 9; i++) begin
      if (i == 6) do_write(5, make_entry(32'h00000000, 0, 16'd9));
      h0 = stat_hits; m0 = stat_misses;
      do_lookup(vecs[i].q, lat);
      if (i == 0) check("latency", lat, 3);
      check($sformatf("vec%0d", i),
            {resp_found, resp_idx, resp_prefix_len, resp_out_port, resp_is_default_route},
            {vecs[i].found, vecs[i].idx, vecs[i].len, vecs[i].port, vecs[i].dflt});
      @(posedge clk); #1;
      check($sformatf("vec%0d_stats", i), {stat_hits - h0, stat_misses - m0},
            vecs[i].found ? 64'h1_0000_0000 : 64'h1);
    end

    // Backpressure: stall 5 cycles with the pipeline full, then drain at one per cycle.
    resp_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send_lookup(vecs[k].q);
      end
      begin
        t = 0;
        while (!resp_valid && t < 50) begin @(posedge clk); #1; t++; end
        snap = dut_resp();
        check("stall_first", snap, model_lookup(vecs[0].q));
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check("stall_hold", dut_resp(), snap);
          check("stall_ready", {resp_valid, lookup_ready, upd_ready}, 3'b100);
        end
        c0 = consumed;
        resp_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("throughput", 32'(consumed - c0), 32'd8);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Update waits for three in-flight lookups to drain, then is visible to the next query.
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_lookup(32'hC0A80001);
    upd_addr = 6'd12; upd_data = make_entry(32'hC0A80000, 16, 16'd12); upd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("drain_block", {upd_ready, lookup_ready}, 2'b00);
    end
    c0 = consumed;
    resp_ready = 1'b1;
    t = 0;
    while (!upd_ready && t < 50) begin @(posedge clk); #1; t++; end
    check("drain_done", {upd_ready, 32'(consumed - c0)}, {1'b1, 32'd3});
    @(posedge clk); #1;
    upd_valid = 1'b0;
    do_lookup(32'hC0A80001, lat);
    check("new_entry", {resp_found, resp_idx, resp_prefix_len, resp_out_port}, {1'b1, 6'd12, 6'd16, 16'd12});
    @(posedge clk); #1;
    clear_all = 1'b1;
    @(posedge clk); #1;
    clear_all = 1'b0;
    do_lookup(32'h0A010203, lat);
    check("after_clear", {resp_found, resp_idx, resp_out_port}, '0);
    @(posedge clk); #1;

    // Saturation of the hit counter from a preloaded value.
    do_write(2, make_entry(32'h0A000000, 8, 16'd4));
    force dut.stat_hits = 32'hFFFF_FFFD;
    m_hits = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    release dut.stat_hits;
    for (int k = 0; k < 3; k++) begin
      do_lookup(32'h0A000001, lat);
      @(posedge clk); #1;
      check($sformatf("sat_hits%0d", k), stat_hits, (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end

    // Reset with lookups in flight.
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_lookup(32'h0A000001);
    @(posedge clk); #1;
    check("pre_reset_busy", resp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_resp", {dut_resp(), resp_valid}, '0);
    check("reset_mid_stats", {stat_hits, stat_misses}, '0);
    check("reset_mid_ready", {lookup_ready, upd_ready}, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b1; resp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale", resp_valid, 1'b0);
    do_lookup(32'h0A000001, lat);
    check("reset_table_empty", resp_found, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic with interleaved updates and random backpressure.
    for (int k = 0; k < 24; k++) do_write(int'($urandom_range(0, N - 1)), rand_entry());
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      acc_l = lookup_valid && lookup_ready;
      acc_u = (upd_valid || clear_all) && upd_ready;
      @(posedge clk); #1;
      if (acc_l) lookup_valid = 1'b0;
      if (acc_u) begin upd_valid = 1'b0; clear_all = 1'b0; end
      resp_ready = ($urandom_range(0, 3) != 0);
      if (!lookup_valid && !upd_valid && !clear_all) begin
        r = int'($urandom_range(0, 99));
        if (r < 5) begin
          upd_addr = 6'($urandom); upd_data = rand_entry(); upd_valid = 1'b1;
        end else if (r == 5 && c > 1800) begin
          clear_all = 1'b1;
        end else if (r < 80) begin
          lookup_dst_ip = rand_query(); lookup_valid = 1'b1;
        end
      end
    end
    @(negedge clk); #1;
    acc_l = lookup_valid && lookup_ready;
    acc_u = (upd_valid || clear_all) && upd_ready;
    @(posedge clk); #1;
    if (acc_l) lookup_valid = 1'b0;
    if (acc_u) begin upd_valid = 1'b0; clear_all = 1'b0; end
    resp_ready = 1'b1;
    t = 0;
    while ((lookup_valid || upd_valid || clear_all) && t < 50) begin
      @(negedge clk); #1;
      acc_l = lookup_valid && lookup_ready;
      acc_u = (upd_valid || clear_all) && upd_ready;
      @(posedge clk); #1;
      if (acc_l) lookup_valid = 1'b0;
      if (acc_u) begin upd_valid = 1'b0; clear_all = 1'b0; end
      t++;
    end
    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lpm_router_searcher.md
# lpm_router_searcher

Parametrised longest-prefix-match successor to the exact-match route searcher. Holds up to `MAX_ENTRIES` route entries, each with its own prefix length. Entries are updated at runtime without an init mode. Returns the longest matching prefix through a 3-stage, fully pipelined, backpressure-aware lookup path, and keeps hit/miss statistics. Sits between the packet-header parser and the egress scheduler in the RDMA forwarding datapath.

## Interface
Parameters:
- `MAX_ENTRIES`, 64: number of table entries; power of two, 2..256.
- `IDX_W`, `$clog2(MAX_ENTRIES)`: index width.
- `ENTRY_WIDTH`, 256: entry width in bits; must be ≥208.
- `IP_WIDTH`, 32: address width; fixed at 32 by the entry layout.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `upd_valid` in 1: table write request.
- `upd_ready` out 1: table write accepted; high only when no lookup is in flight.
- `upd_addr` in `IDX_W`: entry index to write.
- `upd_data` in `ENTRY_WIDTH`: entry to write.
- `clear_all` in 1: invalidate every entry in one cycle; has priority over `upd_valid`.
- `lookup_valid` in 1, `lookup_ready` out 1, `lookup_dst_ip` in 32: query handshake and address.
- `resp_valid` out 1, `resp_ready` in 1: response handshake.
- `resp_found`, `resp_is_default_route`, `resp_is_direct_host`, `resp_is_broadcast`: out 1 each.
- `resp_prefix_len` out 6; `resp_idx` out `IDX_W`.
- `resp_out_port`, `resp_out_qp`, `resp_next_hop_port`, `resp_next_hop_qp`: out 16 each.
- `resp_next_hop_ip` out 32; `resp_next_hop_mac` out 48.
- `stat_hits`, `stat_misses`: out 32 each; saturating counters.

## Operation
Entry layout (little-endian):
- `[31:0]` dst_ip; `[32]` valid; `[40]` is_direct_host; `[48]` is_broadcast; `[61:56]` prefix_len.
- `[79:64]` out_port; `[95:80]` out_qp; `[127:96]` next_hop_ip; `[143:128]` next_hop_port; `[159:144]` next_hop_qp; `[207:160]` next_hop_mac.

Matching rules:
- prefix_len values above 32 are clamped to 32 when the entry is written.
- mask = 0 when len = 0; otherwise `~0 << (32-len)`.
- Entry i matches when valid_i && ((dst_ip_i ^ query) & mask_i) == 0.
- Winner is the matching entry with the largest len. Ties go to the lowest index.
- A len-0 entry is the default route; it matches every query. `resp_is_default_route` = found && winning len == 0.
- There is no special default-route slot. Multiple len-0 entries follow the tie rule.

Pipeline:
- S1 registers the query.
- S2 runs the parallel compare and prefix-length priority select, and registers idx, found and len.
- S3 reads the table.
- The output register parses fields.
- On a miss, all resp data fields are 0 and `resp_found` = 0.

Flow control:
- The pipeline advances when `!resp_valid || resp_ready`.
- `lookup_ready` = advance && !`upd_valid` && !`clear_all`. Updates win a simultaneous conflict.
- `upd_ready` is high only when S1, S2 and S3 are empty and `resp_valid` is low. Lookups therefore never see a half-applied update.
- Writes and clears take effect at the accepting edge.

Statistics:
- Counted when a response is consumed (`resp_valid && resp_ready`).
- found → `stat_hits`++; otherwise `stat_misses`++.
- Both saturate at `32'hFFFFFFFF`.

## Timing
- Reset: all entries invalid; pipeline empty; all outputs 0, except `lookup_ready` = 1 and `upd_ready` = 1 (combinational from the empty pipeline).
- Latency: accepted at edge E → `resp_valid` high after edge E+3, with no backpressure.
- Throughput: one lookup per cycle.
- Stall: while `resp_valid && !resp_ready`, every stage and output holds stable. Bubbles are not squeezed.
- Order: responses return strictly in acceptance order.
- `clear_all` and `upd_valid` are taken only when `upd_ready` is high. Asserting either while lookups are in flight just waits, and blocks new lookups so the pipeline drains.
- Reset mid-operation discards in-flight lookups, table contents and counters.

## Test plan
- Reset, then write idx0 = 10.0.0.0/8 port 1 and idx1 = 10.1.0.0/16 port 2. Query 10.1.2.3 → resp after 3 cycles: found, idx 1, len 16, port 2.
- Write idx5 = 0.0.0.0/0 port 9. Query 192.168.0.1 → found, default_route = 1, port 9. Without idx5 → found = 0, all fields 0, `stat_misses` increments.
- Same /24 prefix at idx 3 and idx 7 → idx 3 wins. Write prefix_len 40 → clamped, reported len 32, exact match only.
- Back-to-back queries with `resp_ready` low for 5 cycles → `lookup_ready` drops, outputs hold, no loss, order preserved, 1/cycle after release.
- Assert `upd_valid` with 3 lookups in flight → `upd_ready` goes high only after the last response is consumed. The next lookup sees the new entry. `clear_all` → all subsequent queries miss.
- Force `stat_hits` near saturation (preload via a long run or a backdoor), then do 2 more hits → counter stays at `32'hFFFFFFFF`. Assert `rst_n` mid-stream → outputs 0 immediately, no stale responses.
